mux_stream_rr: RTL and testbench

Parametrised N:1 stream multiplexer with valid/ready handshakes on every input and on the output, and a registered output stage. It selects among N channels of WIDTH-bit data, either by an externally driven select (fixed mode) or by round-robin arbitration across valid channels. It is the successor to the combinational 2:1 mux and sits between multiple producers and a single consumer wherever source selection must be lossless under back-pressure.

---
 rtl/mux_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/mux_stream_rr.sv | 110 +++++++++++
 tb/tb_mux_stream_rr.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and types for the N:1 stream mux.
// Mode encodings and output-stage state.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches ptr+1, ptr+2, ... mod N for the first request.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_valid
);

  // first requester after ptr wins; wraps back to ptr itself last
  always_comb begin
    logic [SELW-1:0] cand;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = SELW'((int'(ptr) + k) % N);
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_stream_rr.sv
// N:1 valid/ready stream mux with registered output.
// Fixed-select or round-robin source selection.
module mux_stream_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  input  logic                 out_ready
);

  import mux_pkg::*;

  out_state_e       st_q, st_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  chan_q, chan_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic [SELW-1:0]  rr_idx;
  logic             rr_valid;
  logic             fx_valid;
  logic [SELW-1:0]  gnt;
  logic             gnt_valid;
  logic [WIDTH-1:0] gnt_data;
  logic             load_en;

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .gnt_idx   (rr_idx),
    .gnt_valid (rr_valid)
  );

  assign out_valid = (st_q == ST_FULL);
  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign load_en   = !out_valid || out_ready;

  // fixed-mode grant; out-of-range sel never matches
  always_comb begin
    fx_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SELW'(i)) fx_valid = in_valid[i];
    end
  end

  // pick grant source by mode and fetch granted data
  always_comb begin
    gnt       = (mode == MODE_RR) ? rr_idx : sel;
    gnt_valid = (mode == MODE_RR) ? rr_valid : fx_valid;
    gnt_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt == SELW'(i)) gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // one-hot ready to the granted channel when the register can load
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = load_en && gnt_valid && (gnt == SELW'(i));
    end
  end

  // output stage next state: load, empty out, or hold
  always_comb begin
    st_d   = st_q;
    data_d = data_q;
    chan_d = chan_q;
    ptr_d  = ptr_q;
    if (load_en) begin
      if (gnt_valid) begin
        st_d   = ST_FULL;
        data_d = gnt_data;
        chan_d = gnt;
        ptr_d  = gnt;
      end else begin
        st_d = ST_EMPTY;
      end
    end
  end

  // state registers; reset gives channel 0 first priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= ST_EMPTY;
      data_q <= '0;
      chan_q <= '0;
      ptr_q  <= SELW'(N - 1);
    end else begin
      st_q   <= st_d;
      data_q <= data_d;
      chan_q <= chan_d;
      ptr_q  <= ptr_d;
    end
  end

endmodule

// File: tb/tb_mux_stream_rr.sv
// Scoreboard bench for mux_stream_rr.
// Directed scenarios followed by random traffic.
module tb_mux_stream_rr;

  import mux_pkg::*;

  localparam int W    = 8;
  localparam int N    = 4;
  localparam int SELW = $clog2(N);

  typedef struct {
    int         ch;
    logic [7:0] d;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             mode;
  logic [SELW-1:0]  sel;
  logic [N-1:0]     in_valid;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [SELW-1:0]  out_chan;
  logic             out_ready;

  mux_stream_rr #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  beat_t      q[$];
  beat_t      log_q[$];
  beat_t      pend_beat;
  bit         pend  = 0;
  bit         keep  = 0;
  int         last  = N - 1;
  logic [7:0] dat [N];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // monitor: compare the presented beat with the scoreboard head
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat actual=%0h required=none",
                   out_data);
        end else begin
          chk("out_chan", 32'(out_chan), 32'(q[0].ch));
          chk("out_data", 32'(out_data), 32'(q[0].d));
          if (out_ready) begin
            log_q.push_back(q[0]);
            void'(q.pop_front());
          end
        end
      end else begin
        chk("out_empty", 32'(q.size()), 32'd0);
      end
    end
  end

  // one cycle: commit last transfer, drive inputs, predict ready
  task automatic step(input logic m, input logic [SELW-1:0] s,
                      input logic [N-1:0] v, input logic r);
    int  g;
    bit  full;
    bit  le;
    logic [N-1:0] exp_rdy;
    @(posedge clk);
    #1;
    if (pend) begin
      q.push_back(pend_beat);
      pend = 0;
    end
    mode      = m;
    sel       = s;
    in_valid  = v;
    out_ready = r;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = dat[i];
    #1;
    full = (q.size() != 0);
    le   = !full || r;
    g    = -1;
    if (m == MODE_FIXED) begin
      if (int'(s) < N && v[s]) g = int'(s);
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && v[(last + k) % N]) g = (last + k) % N;
      end
    end
    exp_rdy = '0;
    if (le && g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (le && g >= 0) begin
      pend         = 1;
      pend_beat.ch = g;
      pend_beat.d  = dat[g];
      last         = g;
      if (!keep) dat[g] = 8'($urandom);
    end
  endtask

  task automatic drain();
    repeat (3) step(MODE_RR, '0, '0, 1'b1);
  endtask

  initial begin
    int c;
    int n0;
    rst       = 1'b1;
    mode      = MODE_FIXED;
    sel       = '0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) dat[i] = 8'($urandom);
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_chan", 32'(out_chan), 32'd0);
    #2 rst = 1'b0;

    // fixed sel=2
    dat[2] = 8'hA5;
    step(MODE_FIXED, 2'd2, 4'b0100, 1'b1);
    chk("fx_ready", 32'(in_ready), 32'h4);
    step(MODE_FIXED, 2'd2, 4'b0000, 1'b1);
    chk("fx_valid", 32'(out_valid), 32'd1);
    chk("fx_data", 32'(out_data), 32'hA5);
    chk("fx_chan", 32'(out_chan), 32'd2);
    drain();

    // round-robin, all valid, fixed data pattern
    keep = 1;
    for (int i = 0; i < N; i++) dat[i] = 8'(8'h10 + i);
    step(MODE_FIXED, 2'd3, 4'b1000, 1'b1);
    drain();
    log_q.delete();
    repeat (8) step(MODE_RR, '0, 4'b1111, 1'b1);
    drain();
    chk("rr_count", 32'(log_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      chk("rr_seq_chan", 32'(log_q[i].ch), 32'(i % N));
      chk("rr_seq_data", 32'(log_q[i].d), 32'(8'h10 + (i % N)));
    end
    keep = 0;

    // back-pressure
    step(MODE_RR, '0, 4'b1111, 1'b1);
    c = last;
    repeat (3) begin
      step(MODE_RR, '0, 4'b1111, 1'b0);
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_chan", 32'(out_chan), 32'(c));
    end
    log_q.delete();
    step(MODE_RR, '0, 4'b1111, 1'b1);
    drain();
    chk("bp_count", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      chk("bp_first", 32'(log_q[0].ch), 32'(c));
      chk("bp_next", 32'(log_q[1].ch), 32'((c + 1) % N));
    end

    // sparse valids
    log_q.delete();
    step(MODE_RR, '0, 4'b0001, 1'b1);
    repeat (4) step(MODE_RR, '0, 4'b1001, 1'b1);
    repeat (3) step(MODE_RR, '0, 4'b0001, 1'b1);
    drain();
    chk("sp_count", 32'(log_q.size()), 32'd8);
    if (log_q.size() == 8) begin
      chk("sp_0", 32'(log_q[0].ch), 32'd0);
      chk("sp_1", 32'(log_q[1].ch), 32'd3);
      chk("sp_2", 32'(log_q[2].ch), 32'd0);
      chk("sp_3", 32'(log_q[3].ch), 32'd3);
      chk("sp_4", 32'(log_q[4].ch), 32'd0);
      for (int i = 5; i < 8; i++) chk("sp_solo", 32'(log_q[i].ch), 32'd0);
    end

    // fixed sel on an idle channel
    step(MODE_FIXED, 2'd0, 4'b0001, 1'b1);
    step(MODE_FIXED, 2'd1, 4'b1101, 1'b1);
    chk("idle_ready", 32'(in_ready), 32'd0);
    step(MODE_FIXED, 2'd1, 4'b1101, 1'b1);
    chk("idle_empty", 32'(out_valid), 32'd0);
    drain();

    // async reset while FULL
    step(MODE_RR, '0, 4'b1111, 1'b0);
    step(MODE_RR, '0, 4'b0000, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    q.delete();
    pend = 0;
    last = N - 1;
    #1 rst = 1'b0;
    log_q.delete();
    step(MODE_RR, '0, 4'b1111, 1'b1);
    drain();
    n0 = log_q.size();
    chk("arst_count", 32'(n0), 32'd1);
    if (n0 > 0) chk("arst_first", 32'(log_q[0].ch), 32'd0);

    // random traffic
    for (int t = 0; t < 400; t++) begin
      step(logic'($urandom_range(0, 1)),
           SELW'($urandom_range(0, N - 1)),
           N'($urandom),
           logic'($urandom_range(0, 3) != 0));
    end
    drain();
    chk("final_queue", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
